// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, redirect squash and global hold.
// Optional HAZARD_STATS_EN adds saturating load-use bubble and flush event counters.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [19:0]     id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            ex_valid,
  output logic [19:0]     ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            stall_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stat_loaduse_cnt,
  output logic [31:0]     stat_flush_cnt
`endif
);

  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_JUMP       = 13;
  localparam int CTRL_STORE      = 14;
  localparam int CTRL_LUI        = 15;

  logic id_uses_rs1;
  logic id_uses_rs2;
  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;
  logic hazard;
  logic bubble;
  logic load_en;

  // LUI and JAL ignore rs1; rs2 is read for R-type/branches and as store data.
  assign id_uses_rs1 = ~(id_ctrl[CTRL_LUI] | id_ctrl[CTRL_JUMP]);
  assign id_uses_rs2 = ~id_ctrl[CTRL_ALU_SRC] | id_ctrl[CTRL_STORE];

  assign ex_is_load = ex_valid & ex_ctrl[CTRL_MEM_TO_REG];
  assign rs1_match  = id_uses_rs1 & (ex_rd == id_rs1);
  assign rs2_match  = id_uses_rs2 & (ex_rd == id_rs2);
  assign hazard     = id_valid & ex_is_load & (ex_rd != 5'd0) & (rs1_match | rs2_match);

  assign stall_o = hazard & ~flush_i;

  // Flush outranks hold so a redirect is never lost during a memory wait.
  assign bubble  = flush_i | (~hold_i & hazard);
  assign load_en = ~flush_i & ~hold_i & ~hazard;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
    end else if (load_en) begin
      ex_valid    <= id_valid;
      ex_ctrl     <= id_valid ? id_ctrl : 20'd0;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
    end
  end

`ifdef HAZARD_STATS_EN
  logic loaduse_evt;

  assign loaduse_evt = hazard & ~flush_i & ~hold_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_loaduse_cnt <= '0;
      stat_flush_cnt   <= '0;
    end else begin
      if (loaduse_evt && stat_loaduse_cnt != 32'hFFFF_FFFF)
        stat_loaduse_cnt <= stat_loaduse_cnt + 32'd1;
      if (flush_i && stat_flush_cnt != 32'hFFFF_FFFF)
        stat_flush_cnt <= stat_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued at drive time
// and popped after each rising edge; stall_o is checked combinationally before the edge.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            v;
    logic [19:0]     ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1d;
    logic [XLEN-1:0] rs2d;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } instr_t;

  localparam logic [19:0] C_ADDI = 20'h000CB;
  localparam logic [19:0] C_ADD  = 20'h00082;
  localparam logic [19:0] C_LW   = 20'h801C2;
  localparam logic [19:0] C_SW   = 20'h84042;
  localparam logic [19:0] C_LUI  = 20'h080C0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [19:0]     id_ctrl;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            flush_i, hold_i;
  logic            ex_valid;
  logic [19:0]     ex_ctrl;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            stall_o;
`ifdef HAZARD_STATS_EN
  logic [31:0]     stat_loaduse_cnt, stat_flush_cnt;
  int unsigned     m_lu_cnt, m_fl_cnt;
`endif

  int     n_checks = 0;
  int     n_fail   = 0;
  instr_t exp_q[$];
  instr_t model;
  logic   last_stall;
  logic [31:0] pc_ctr = 32'h100;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .stall_o(stall_o)
`ifdef HAZARD_STATS_EN
    , .stat_loaduse_cnt(stat_loaduse_cnt), .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [19:0] ctrl, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc);
    instr_t t;
    t.v = v; t.ctrl = ctrl; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.pc = pc;
    t.rs1d = 32'hA000_0000 ^ (pc << 4) ^ {27'd0, rs1};
    t.rs2d = 32'h0B00_0000 ^ (pc << 8) ^ {27'd0, rs2};
    return t;
  endfunction

  function automatic instr_t next_pc_instr(input logic [19:0] ctrl, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
    pc_ctr = pc_ctr + 32'd4;
    return mk(1'b1, ctrl, rd, rs1, rs2, imm, pc_ctr);
  endfunction

  function automatic logic model_hazard(input instr_t id);
    logic u1, u2;
    u1 = !(id.ctrl[15] | id.ctrl[13]);
    u2 = !id.ctrl[6] | id.ctrl[14];
    return id.v & model.v & model.ctrl[8] & (model.rd != 5'd0) &
           ((u1 & (model.rd == id.rs1)) | (u2 & (model.rd == id.rs2)));
  endfunction

  task automatic compare_ex(input instr_t e);
    check("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
    check("ex_ctrl", {12'd0, ex_ctrl}, {12'd0, e.ctrl});
    check("ex_pc", ex_pc, e.pc);
    check("ex_rs1_data", ex_rs1_data, e.rs1d);
    check("ex_rs2_data", ex_rs2_data, e.rs2d);
    check("ex_imm", ex_imm, e.imm);
    check("ex_rs1", {27'd0, ex_rs1}, {27'd0, e.rs1});
    check("ex_rs2", {27'd0, ex_rs2}, {27'd0, e.rs2});
    check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
  endtask

  task automatic step(input instr_t id, input logic rst, input logic flush, input logic hold);
    instr_t e;
    logic   hz;
    @(negedge clk);
    rst_n = ~rst;
    id_valid = id.v; id_ctrl = id.ctrl; id_pc = id.pc;
    id_rs1_data = id.rs1d; id_rs2_data = id.rs2d; id_imm = id.imm;
    id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
    flush_i = flush; hold_i = hold;
    #1;
    hz = model_hazard(id);
    last_stall = stall_o;
    check("stall", {31'd0, stall_o}, {31'd0, hz & ~flush});
    if (rst || flush || (!hold && hz)) e = '0;
    else if (hold) e = model;
    else begin
      e = id;
      if (!id.v) e.ctrl = '0;
    end
`ifdef HAZARD_STATS_EN
    if (rst) begin m_lu_cnt = 0; m_fl_cnt = 0; end
    else begin
      if (hz && !flush && !hold) m_lu_cnt++;
      if (flush) m_fl_cnt++;
    end
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      compare_ex(e);
      model = e;
    end
`ifdef HAZARD_STATS_EN
    check("stat_loaduse", stat_loaduse_cnt, m_lu_cnt);
    check("stat_flush", stat_flush_cnt, m_fl_cnt);
`endif
  endtask

  instr_t nop, addi, add, lw, sw, held;

  initial begin
    model = '0;
    nop = mk(1'b0, 20'h0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
`ifdef HAZARD_STATS_EN
    m_lu_cnt = 0; m_fl_cnt = 0;
`endif
    // Reset with junk on the inputs; the DUT starts from unknown state, so the
    // stall comparison is skipped on the first reset edge by resetting twice first.
    rst_n = 1'b0; id_valid = 1'b1; id_ctrl = C_LW; id_pc = '1; id_rs1_data = '1;
    id_rs2_data = '1; id_imm = '1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    flush_i = 1'b0; hold_i = 1'b0;
    repeat (2) @(posedge clk);
    step(mk(1'b1, C_LW, 5'd7, 5'd7, 5'd7, 32'hFFFF, 32'h40), 1'b1, 1'b0, 1'b0);
    check("reset_valid", {31'd0, ex_valid}, 32'd0);

    // Plain flow: ADDI x5,x0,7 then ADD x6,x5,x5
    addi = next_pc_instr(C_ADDI, 5'd5, 5'd0, 5'd0, 32'd7);
    add  = next_pc_instr(C_ADD, 5'd6, 5'd5, 5'd5, 32'd0);
    step(addi, 1'b0, 1'b0, 1'b0);
    check("flow_imm", ex_imm, 32'd7);
    check("flow_rd0", {27'd0, ex_rd}, 32'd5);
    step(add, 1'b0, 1'b0, 1'b0);
    check("flow_nostall", {31'd0, last_stall}, 32'd0);
    check("flow_rd1", {27'd0, ex_rd}, 32'd6);

    // Reset mid-stream with an ADD sitting in EX
    step(nop, 1'b1, 1'b0, 1'b0);
    check("rst_mid_ctrl", {12'd0, ex_ctrl}, 32'd0);
    step(nop, 1'b0, 1'b0, 1'b0);
    check("rst_mid_stall", {31'd0, last_stall}, 32'd0);

    // Load-use through rs1/rs2 of an ADD
    lw  = next_pc_instr(C_LW, 5'd5, 5'd1, 5'd0, 32'd0);
    add = next_pc_instr(C_ADD, 5'd6, 5'd5, 5'd2, 32'd0);
    step(lw, 1'b0, 1'b0, 1'b0);
    step(add, 1'b0, 1'b0, 1'b0);
    check("lu_stall", {31'd0, last_stall}, 32'd1);
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    step(add, 1'b0, 1'b0, 1'b0);
    check("lu_release", {31'd0, last_stall}, 32'd0);
    check("lu_add_in_ex", ex_pc, add.pc);

    // Load-use via store data (rs2 path)
    lw = next_pc_instr(C_LW, 5'd5, 5'd1, 5'd0, 32'd0);
    sw = next_pc_instr(C_SW, 5'd0, 5'd3, 5'd5, 32'd0);
    step(lw, 1'b0, 1'b0, 1'b0);
    step(sw, 1'b0, 1'b0, 1'b0);
    check("sw_stall", {31'd0, last_stall}, 32'd1);
    step(sw, 1'b0, 1'b0, 1'b0);
    check("sw_release", {31'd0, last_stall}, 32'd0);
    check("sw_in_ex", {12'd0, ex_ctrl}, {12'd0, C_SW});
`ifdef HAZARD_STATS_EN
    check("stat_lu_two", stat_loaduse_cnt, 32'd2);
`endif

    // No false hazards: x0 destination, LUI, unused rs2 of ADDI
    step(next_pc_instr(C_LW, 5'd0, 5'd1, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
    step(next_pc_instr(C_ADD, 5'd6, 5'd0, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
    check("x0_nostall", {31'd0, last_stall}, 32'd0);
    step(next_pc_instr(C_LW, 5'd5, 5'd1, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
    step(next_pc_instr(C_LUI, 5'd5, 5'd5, 5'd5, 32'h1000), 1'b0, 1'b0, 1'b0);
    check("lui_nostall", {31'd0, last_stall}, 32'd0);
    step(next_pc_instr(C_LW, 5'd5, 5'd1, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
    step(next_pc_instr(C_ADDI, 5'd6, 5'd7, 5'd5, 32'd5), 1'b0, 1'b0, 1'b0);
    check("addi_rs2_nostall", {31'd0, last_stall}, 32'd0);

    // Flush beats hazard
    step(next_pc_instr(C_LW, 5'd5, 5'd1, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
    step(next_pc_instr(C_ADD, 5'd6, 5'd5, 5'd2, 32'd0), 1'b0, 1'b1, 1'b0);
    check("flush_nostall", {31'd0, last_stall}, 32'd0);
    check("flush_bubble", {12'd0, ex_ctrl}, 32'd0);

    // Hold for three cycles with an ADD in EX, then hold+flush
    held = next_pc_instr(C_ADD, 5'd9, 5'd10, 5'd11, 32'd0);
    step(held, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(next_pc_instr(C_ADDI, 5'd12, 5'd13, 5'd0, 32'd99), 1'b0, 1'b0, 1'b1);
      check("hold_pc", ex_pc, held.pc);
    end
    step(next_pc_instr(C_ADD, 5'd12, 5'd13, 5'd14, 32'd0), 1'b0, 1'b1, 1'b1);
    check("hold_flush_bubble", {31'd0, ex_valid}, 32'd0);

    // Back-to-back loads, and a hazard under hold (stall stays up, EX unchanged)
    lw = next_pc_instr(C_LW, 5'd5, 5'd1, 5'd0, 32'd0);
    step(lw, 1'b0, 1'b0, 1'b0);
    held = next_pc_instr(C_LW, 5'd6, 5'd5, 5'd0, 32'd4);
    step(held, 1'b0, 1'b0, 1'b1);
    check("hold_hz_stall", {31'd0, last_stall}, 32'd1);
    check("hold_hz_keep", ex_pc, lw.pc);
    step(held, 1'b0, 1'b0, 1'b0);
    check("b2b_stall", {31'd0, last_stall}, 32'd1);
    step(held, 1'b0, 1'b0, 1'b0);
    check("b2b_load2", ex_pc, held.pc);

    // Invalid ID slot loads a bubble-equivalent
    step(mk(1'b0, C_LW, 5'd5, 5'd6, 5'd6, 32'd3, 32'h800), 1'b0, 1'b0, 1'b0);
    check("invalid_ctrl", {12'd0, ex_ctrl}, 32'd0);
    step(nop, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
